lsu_ctrl: RTL and testbench

//  Load/store control stage between execute and the data-memory port. Accepts one access per

---
 rtl/lsu_if.sv | 29 ++
 rtl/lsu_ctrl.sv | 115 +++++++++++
 tb/tb_lsu_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// lsu_if: execute-side request, memory-port and result signals of the load/store stage.
interface lsu_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_we;
   logic [2:0]  in_op;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rdata;
   logic [1:0]  out_fault;
   modport slave (
      input  in_valid, in_we, in_op, in_addr, in_wdata, mem_gnt, mem_rvalid, mem_rdata, out_ready,
      output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, out_valid, out_rdata, out_fault
   );
   modport master (
      output in_valid, in_we, in_op, in_addr, in_wdata, mem_gnt, mem_rvalid, mem_rdata, out_ready,
      input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, out_valid, out_rdata, out_fault
   );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store stage with alignment/op checks, lane steering,
// load extension and a bounded memory wait that turns silence into a timeout fault.
module lsu_ctrl #(
   parameter int TIMEOUT = 16
) (
   input logic   clk,
   input logic   rst_n,
   lsu_if.slave  lsu_io
);
   localparam int TW = $clog2(TIMEOUT + 2);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  op_q, op_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic [31:0] out_rdata_q, out_rdata_d;
   logic [1:0]  out_fault_q, out_fault_d;
   logic [TW-1:0] timer_q, timer_d, tmr_inc;
   logic        illegal, misal, tmo;
   logic [31:0] wdata_lane, rd_sh, ext;
   logic [3:0]  strb_lane;
   assign illegal    = lsu_io.in_op inside {3'b011, 3'b110, 3'b111};
   assign misal      = (lsu_io.in_op[1:0] == 2'b01 && lsu_io.in_addr[0]) ||
                       (lsu_io.in_op[1:0] == 2'b10 && lsu_io.in_addr[1:0] != 2'b00);
   assign wdata_lane = lsu_io.in_op[1:0] == 2'b00 ? {4{lsu_io.in_wdata[7:0]}} :
                       lsu_io.in_op[1:0] == 2'b01 ? {2{lsu_io.in_wdata[15:0]}} : lsu_io.in_wdata;
   assign strb_lane  = lsu_io.in_op[1:0] == 2'b00 ? 4'b0001 << lsu_io.in_addr[1:0] :
                       lsu_io.in_op[1:0] == 2'b01 ? (lsu_io.in_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   // op[2] marks the unsigned variants, so it suppresses the sign fill
   assign rd_sh      = lsu_io.mem_rdata >> {off_q, 3'b000};
   assign ext        = op_q[1:0] == 2'b00 ? {{24{rd_sh[7] & ~op_q[2]}}, rd_sh[7:0]} :
                       op_q[1:0] == 2'b01 ? {{16{rd_sh[15] & ~op_q[2]}}, rd_sh[15:0]} : rd_sh;
   assign tmr_inc    = timer_q + TW'(1);
   assign tmo        = TIMEOUT != 0 && int'(tmr_inc) == TIMEOUT - 1;
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      op_d        = op_q;
      off_d       = off_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      out_rdata_d = out_rdata_q;
      out_fault_d = out_fault_q;
      timer_d     = timer_q;
      case (state_q)
         IDLE: if (lsu_io.in_valid) begin
            we_d        = lsu_io.in_we;
            op_d        = lsu_io.in_op;
            off_d       = lsu_io.in_addr[1:0];
            mem_addr_d  = {lsu_io.in_addr[31:2], 2'b00};
            mem_wdata_d = wdata_lane;
            mem_wstrb_d = lsu_io.in_we ? strb_lane : 4'b0000;
            out_rdata_d = '0;
            out_fault_d = illegal ? 2'b10 : misal ? 2'b01 : 2'b00;
            state_d     = (illegal || misal) ? RESP : REQ;
         end
         REQ: if (lsu_io.mem_gnt) begin
            state_d = WAIT;
            timer_d = '0;
         end
         WAIT: if (lsu_io.mem_rvalid) begin
            out_rdata_d = we_q ? 32'h0 : ext;
            out_fault_d = 2'b00;
            state_d     = RESP;
         end else begin
            timer_d = tmr_inc;
            if (tmo) begin
               out_rdata_d = '0;
               out_fault_d = 2'b11;
               state_d     = RESP;
            end
         end
         RESP: if (lsu_io.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         op_q        <= '0;
         off_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         out_rdata_q <= '0;
         out_fault_q <= '0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         op_q        <= op_d;
         off_q       <= off_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         out_rdata_q <= out_rdata_d;
         out_fault_q <= out_fault_d;
         timer_q     <= timer_d;
      end
   end
   assign lsu_io.in_ready  = state_q == IDLE;
   assign lsu_io.mem_req   = state_q == REQ;
   assign lsu_io.mem_we    = we_q;
   assign lsu_io.mem_addr  = mem_addr_q;
   assign lsu_io.mem_wdata = mem_wdata_q;
   assign lsu_io.mem_wstrb = mem_wstrb_q;
   assign lsu_io.out_valid = state_q == RESP;
   assign lsu_io.out_rdata = out_rdata_q;
   assign lsu_io.out_fault = out_fault_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed accesses with a queued scoreboard checked by an independent result monitor.
module tb_lsu_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   typedef struct packed {logic [31:0] rd; logic [1:0] f;} exp_t;
   exp_t sb[$];
   lsu_if bus();
   lsu_ctrl #(.TIMEOUT(16)) dut (.clk(clk), .rst_n(rst_n), .lsu_io(bus));
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("out_rdata", bus.out_rdata, e.rd);
            chk("out_fault", 32'(bus.out_fault), 32'(e.f));
         end
      end
   end
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   // rdly < 0 means the memory never answers; the stage should time out
   task automatic do_acc(input string nm, input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd, input int gdly, input int rdly,
                         input logic [31:0] rdata, input logic [31:0] exp_rd, input logic [1:0] exp_f,
                         input logic [31:0] exp_wd, input logic [3:0] exp_st, input int hold);
      int n;
      chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_we    = we;
      bus.in_op    = op;
      bus.in_addr  = addr;
      bus.in_wdata = wd;
      sb.push_back('{rd: exp_rd, f: exp_f});
      cyc();
      bus.in_valid = 1'b0;
      bus.in_wdata = 32'hFFFF_FFFF;
      if (exp_f == 2'b00 || exp_f == 2'b11) begin
         for (int i = 0; i <= gdly; i++) begin
            chk({nm, "_req"}, 32'(bus.mem_req), 32'd1);
            chk({nm, "_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
            chk({nm, "_we"}, 32'(bus.mem_we), 32'(we));
            chk({nm, "_wstrb"}, 32'(bus.mem_wstrb), 32'(exp_st));
            if (we) chk({nm, "_wdata"}, bus.mem_wdata, exp_wd);
            bus.mem_gnt = (i == gdly);
            cyc();
         end
         bus.mem_gnt = 1'b0;
         if (rdly >= 0) begin
            repeat (rdly) begin
               chk({nm, "_wait_req"}, 32'(bus.mem_req), 32'd0);
               cyc();
            end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
            cyc();
            bus.mem_rvalid = 1'b0;
         end else begin
            n = 0;
            while (!bus.out_valid && n < 40) begin
               cyc();
               n++;
            end
            chk({nm, "_tmo_cycles"}, 32'(n), 32'd15);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'h5555_AAAA;
            cyc();
            bus.mem_rvalid = 1'b0;
         end
      end else chk({nm, "_no_req"}, 32'(bus.mem_req), 32'd0);
      chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
      repeat (hold) begin
         cyc();
         chk({nm, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
         chk({nm, "_hold_rdata"}, bus.out_rdata, exp_rd);
      end
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
      chk({nm, "_done_valid"}, 32'(bus.out_valid), 32'd0);
      chk({nm, "_idle"}, 32'(bus.in_ready), 32'd1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.in_valid = 0; bus.in_we = 0; bus.in_op = 0; bus.in_addr = 0; bus.in_wdata = 0;
      bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.out_ready = 0;
      @(negedge clk);
      chk("rst_req", 32'(bus.mem_req), 32'd0);
      chk("rst_we", 32'(bus.mem_we), 32'd0);
      chk("rst_addr", bus.mem_addr, 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      chk("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_rdata", bus.out_rdata, 32'd0);
      chk("rst_fault", 32'(bus.out_fault), 32'd0);
      chk("rst_ready", 32'(bus.in_ready), 32'd1);
      cyc();
      rst_n = 1'b1;
      cyc();
      do_acc("lw",   0, 3'b010, 32'h8000_0004, 0, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 0, 4'b0000, 0);
      do_acc("lb",   0, 3'b000, 32'h8000_0003, 0, 0, 0, 32'h8011_2233, 32'hFFFF_FF80, 2'b00, 0, 4'b0000, 0);
      do_acc("lbu",  0, 3'b100, 32'h8000_0003, 0, 0, 0, 32'h8011_2233, 32'h0000_0080, 2'b00, 0, 4'b0000, 0);
      do_acc("sh",   1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 1, 1, 32'h1111_1111, 32'h0, 2'b00, 32'hABCD_ABCD, 4'b1100, 0);
      do_acc("lw_mis", 0, 3'b010, 32'h8000_0002, 0, 0, 0, 0, 32'h0, 2'b01, 0, 4'b0000, 0);
      do_acc("op011", 0, 3'b011, 32'h8000_0002, 0, 0, 0, 0, 32'h0, 2'b10, 0, 4'b0000, 0);
      do_acc("tmo",  0, 3'b010, 32'h8000_0010, 0, 5, -1, 0, 32'h0, 2'b11, 0, 4'b0000, 0);
      do_acc("lh_hold", 0, 3'b001, 32'h8000_0002, 0, 0, 2, 32'h8001_1234, 32'hFFFF_8001, 2'b00, 0, 4'b0000, 3);
      do_acc("lhu",  0, 3'b101, 32'h8000_0000, 0, 0, 0, 32'h1234_F00D, 32'h0000_F00D, 2'b00, 0, 4'b0000, 0);
      do_acc("sb",   1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 2, 3, 0, 32'h0, 2'b00, 32'hA5A5_A5A5, 4'b0010, 0);
      do_acc("sw",   1, 3'b010, 32'h8000_0008, 32'h1234_5678, 0, 0, 0, 32'h0, 2'b00, 32'h1234_5678, 4'b1111, 1);
      do_acc("lb1",  0, 3'b000, 32'h8000_0001, 0, 0, 0, 32'h0000_7F00, 32'h0000_007F, 2'b00, 0, 4'b0000, 0);
      do_acc("lhu_mis", 0, 3'b101, 32'h8000_0001, 0, 0, 0, 0, 32'h0, 2'b01, 0, 4'b0000, 0);
      do_acc("op111", 1, 3'b111, 32'h8000_0000, 0, 0, 0, 0, 32'h0, 2'b10, 0, 4'b0000, 0);
      do_acc("sbu",  1, 3'b100, 32'h8000_0002, 32'h0000_003C, 0, 0, 0, 32'h0, 2'b00, 32'h3C3C_3C3C, 4'b0100, 0);
      bus.in_valid = 1'b1; bus.in_we = 1'b0; bus.in_op = 3'b010; bus.in_addr = 32'h8000_0020;
      cyc();
      bus.in_valid = 1'b0;
      chk("rst_req_pre", 32'(bus.mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req_async", 32'(bus.mem_req), 32'd0);
      chk("rst_req_ready", 32'(bus.in_ready), 32'd1);
      cyc();
      rst_n = 1'b1;
      cyc();
      bus.in_valid = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
      bus.mem_gnt = 1'b1;
      cyc();
      bus.mem_gnt = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_wait_req", 32'(bus.mem_req), 32'd0);
      chk("rst_wait_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_wait_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_wait_addr", bus.mem_addr, 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();
      do_acc("lw_after", 0, 3'b010, 32'h8000_0004, 0, 0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'b00, 0, 4'b0000, 0);
      cyc();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
